// File: rtl/parking_occupancy_tracker.sv
// -----------------------------------------------------------------------------
// parking_occupancy_tracker
//
// Purpose:
//   Clocked, parametrised occupancy tracker for the parking-lot sensors.
//   Every raw spot sensor passes through a two-flop synchroniser and then a
//   per-spot debounce counter. Accepted changes update a registered
//   occupancy map. The block also produces a spots-left count, full and empty
//   flags, one-cycle arrival/departure pulses and a wrapping count of entries.
//
// Optional feature macro:
//   PARKING_PEAK_TRACK_EN - when defined, peak_occ_o tracks the highest
//                           occupancy seen since reset or the last
//                           clear_stats_i. When undefined, peak_occ_o is tied
//                           to 0 and no peak register exists.
//
// Parameters:
//   N_SPOTS  - number of parking spots (>= 1)
//   DEBOUNCE - number of consecutive synchronised cycles a change must
//              persist before it is accepted (>= 1)
//   ENTRY_W  - width of the total-entries counter
//   CNT_W    - derived width of the count outputs (local, not overridable)
//
// Ports:
//   clk_i           in   1        system clock; all state changes on the
//                                 rising edge
//   reset_i         in   1        asynchronous active-high reset
//   spot_sense_i    in   N_SPOTS  raw sensors, 1 = car parked; these are
//                                 asynchronous to clk_i
//   clear_stats_i   in   1        synchronous clear of the statistics
//   occupied_o      out  N_SPOTS  debounced occupancy map
//   spots_left_o    out  CNT_W    N_SPOTS minus the number of occupied spots
//   full_o          out  1        high when no spots are left
//   empty_o         out  1        high when every spot is free
//   arrive_pulse_o  out  1        at least one spot went 0->1 this update
//   depart_pulse_o  out  1        at least one spot went 1->0 this update
//   total_entries_o out  ENTRY_W  running count of accepted arrivals, wraps
//   peak_occ_o      out  CNT_W    peak occupancy (0 without the macro)
// -----------------------------------------------------------------------------
module parking_occupancy_tracker #(
  parameter  int N_SPOTS  = 3,
  parameter  int DEBOUNCE = 4,
  parameter  int ENTRY_W  = 8,
  localparam int CNT_W    = $clog2(N_SPOTS + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [N_SPOTS-1:0] spot_sense_i,
  input  logic               clear_stats_i,
  output logic [N_SPOTS-1:0] occupied_o,
  output logic [CNT_W-1:0]   spots_left_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               arrive_pulse_o,
  output logic               depart_pulse_o,
  output logic [ENTRY_W-1:0] total_entries_o,
  output logic [CNT_W-1:0]   peak_occ_o
);

  // The debounce counter only has to reach DEBOUNCE-1. At that point the
  // next mismatching edge is the DEBOUNCE-th one, and it accepts the change.
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] SPOTS_CNT = CNT_W'(N_SPOTS);

  function automatic logic [CNT_W-1:0] popcount(input logic [N_SPOTS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  logic [N_SPOTS-1:0]           sync1_q;
  logic [N_SPOTS-1:0]           sync2_q;
  logic [N_SPOTS-1:0][DB_W-1:0] cnt_q;
  logic [N_SPOTS-1:0][DB_W-1:0] cnt_d;
  logic [N_SPOTS-1:0]           occ_q;
  logic [N_SPOTS-1:0]           occ_d;
  logic                         arrive_q;
  logic                         arrive_d;
  logic                         depart_q;
  logic                         depart_d;
  logic [ENTRY_W-1:0]           total_q;
  logic [ENTRY_W-1:0]           total_d;

  logic [N_SPOTS-1:0]           toggle;
  logic [N_SPOTS-1:0]           rises;
  logic [N_SPOTS-1:0]           falls;
  logic [CNT_W-1:0]             arr_cnt;
  logic [CNT_W-1:0]             occ_cnt;

  // Two-flop synchroniser for the raw sensor inputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= spot_sense_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-spot debounce. A spot whose synchronised input agrees with its
  // accepted state holds its counter at zero. This also rejects any glitch
  // that returns to match before the counter has reached its last value.
  always_comb begin
    cnt_d  = cnt_q;
    toggle = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      if (sync2_q[i] == occ_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        cnt_d[i]  = '0;
        toggle[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_comb begin
    rises    = toggle & ~occ_q;
    falls    = toggle & occ_q;
    occ_d    = occ_q ^ toggle;
    arrive_d = |rises;
    depart_d = |falls;
    arr_cnt  = popcount(rises);
    // A clear wins over arrivals on the same edge; those arrivals are lost.
    if (clear_stats_i) begin
      total_d = '0;
    end else begin
      total_d = total_q + ENTRY_W'(arr_cnt);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      occ_q    <= '0;
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
      total_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      arrive_q <= arrive_d;
      depart_q <= depart_d;
      total_q  <= total_d;
    end
  end

  // These status outputs come only from the occupancy register, so there is
  // no combinational path from the sensor pins to them.
  assign occ_cnt        = popcount(occ_q);
  assign spots_left_o   = SPOTS_CNT - occ_cnt;
  assign full_o         = (spots_left_o == '0);
  assign empty_o        = (spots_left_o == SPOTS_CNT);
  assign occupied_o     = occ_q;
  assign arrive_pulse_o = arrive_q;
  assign depart_pulse_o = depart_q;
  assign total_entries_o = total_q;

`ifdef PARKING_PEAK_TRACK_EN
  logic [CNT_W-1:0] peak_q;
  logic [CNT_W-1:0] peak_d;

  // The peak samples the registered occupancy, so it trails occupied_o by
  // one cycle. A clear restarts tracking from the occupancy at that moment.
  always_comb begin
    if (clear_stats_i) begin
      peak_d = occ_cnt;
    end else if (occ_cnt > peak_q) begin
      peak_d = occ_cnt;
    end else begin
      peak_d = peak_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_occ_o = peak_q;
`else
  assign peak_occ_o = '0;
`endif

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
module tb_parking_occupancy_tracker;

  logic       clk;
  logic       reset;
  logic [2:0] spot_sense;
  logic       clear_stats;
  logic [2:0] occupied;
  logic [1:0] spots_left;
  logic       full;
  logic       empty;
  logic       arrive_pulse;
  logic       depart_pulse;
  logic [7:0] total_entries;
  logic [1:0] peak_occ;

  // Second instance with a narrow entry counter so that wrap-around can be
  // exercised.
  logic [2:0] spot_sense2;
  logic       clear_stats2;
  logic [2:0] occupied2;
  logic [1:0] spots_left2;
  logic       full2;
  logic       empty2;
  logic       arrive_pulse2;
  logic       depart_pulse2;
  logic [1:0] total_entries2;
  logic [1:0] peak_occ2;

  int chk_total;
  int chk_pass;

  parking_occupancy_tracker #(.N_SPOTS(3), .DEBOUNCE(4), .ENTRY_W(8)) dut (
    .clk_i(clk), .reset_i(reset), .spot_sense_i(spot_sense),
    .clear_stats_i(clear_stats), .occupied_o(occupied),
    .spots_left_o(spots_left), .full_o(full), .empty_o(empty),
    .arrive_pulse_o(arrive_pulse), .depart_pulse_o(depart_pulse),
    .total_entries_o(total_entries), .peak_occ_o(peak_occ)
  );

  parking_occupancy_tracker #(.N_SPOTS(3), .DEBOUNCE(4), .ENTRY_W(2)) dut_w2 (
    .clk_i(clk), .reset_i(reset), .spot_sense_i(spot_sense2),
    .clear_stats_i(clear_stats2), .occupied_o(occupied2),
    .spots_left_o(spots_left2), .full_o(full2), .empty_o(empty2),
    .arrive_pulse_o(arrive_pulse2), .depart_pulse_o(depart_pulse2),
    .total_entries_o(total_entries2), .peak_occ_o(peak_occ2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; spot_sense = 3'b111; clear_stats = 1'b0;
    spot_sense2 = 3'b000; clear_stats2 = 1'b0;
    #12;
    chk_total++; if (occupied !== 3'b000) $display("FAIL rst_occ: got %b want 000", occupied); else chk_pass++;
    chk_total++; if (spots_left !== 2'd3) $display("FAIL rst_left: got %0d want 3", spots_left); else chk_pass++;
    chk_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_flags: got empty=%b full=%b want 1/0", empty, full); else chk_pass++;
    chk_total++; if (total_entries !== 8'd0) $display("FAIL rst_total: got %0d want 0", total_entries); else chk_pass++;
    chk_total++; if (arrive_pulse !== 1'b0 || depart_pulse !== 1'b0 || peak_occ !== 2'd0)
      $display("FAIL rst_pulses: got arr=%b dep=%b peak=%0d want 0/0/0", arrive_pulse, depart_pulse, peak_occ); else chk_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    tick(5);
    chk_total++; if (occupied !== 3'b000) $display("FAIL rel_early: got %b want 000 after 5 edges", occupied); else chk_pass++;
    tick(1);
    chk_total++; if (occupied !== 3'b111) $display("FAIL rel_occ: got %b want 111", occupied); else chk_pass++;
    chk_total++; if (spots_left !== 2'd0 || full !== 1'b1 || empty !== 1'b0)
      $display("FAIL rel_flags: got left=%0d full=%b empty=%b want 0/1/0", spots_left, full, empty); else chk_pass++;
    chk_total++; if (arrive_pulse !== 1'b1 || depart_pulse !== 1'b0)
      $display("FAIL rel_pulse: got arr=%b dep=%b want 1/0", arrive_pulse, depart_pulse); else chk_pass++;
    chk_total++; if (total_entries !== 8'd3) $display("FAIL rel_total: got %0d want 3", total_entries); else chk_pass++;
    tick(1);
    chk_total++; if (arrive_pulse !== 1'b0) $display("FAIL rel_pulse_len: got arr=%b want 0", arrive_pulse); else chk_pass++;
  endtask

  task automatic test_glitch();
    int bad;
    spot_sense = 3'b000;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    spot_sense = 3'b010;
    tick(3);
    spot_sense = 3'b000;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (occupied !== 3'b000 || arrive_pulse !== 1'b0 || depart_pulse !== 1'b0) bad++;
    end
    chk_total++; if (bad !== 0) $display("FAIL glitch_reject: got %0d bad cycles want 0", bad); else chk_pass++;
    spot_sense = 3'b010;
    tick(5);
    chk_total++; if (occupied !== 3'b000) $display("FAIL hold_early: got %b want 000", occupied); else chk_pass++;
    tick(1);
    chk_total++; if (occupied !== 3'b010 || spots_left !== 2'd2)
      $display("FAIL hold_occ: got occ=%b left=%0d want 010/2", occupied, spots_left); else chk_pass++;
    chk_total++; if (arrive_pulse !== 1'b1 || depart_pulse !== 1'b0 || total_entries !== 8'd1)
      $display("FAIL hold_pulse: got arr=%b dep=%b total=%0d want 1/0/1", arrive_pulse, depart_pulse, total_entries); else chk_pass++;
  endtask

  task automatic test_back_to_back();
    spot_sense = 3'b101;
    tick(5);
    chk_total++; if (occupied !== 3'b010) $display("FAIL mix_early: got %b want 010", occupied); else chk_pass++;
    tick(1);
    chk_total++; if (occupied !== 3'b101 || spots_left !== 2'd1)
      $display("FAIL mix_occ: got occ=%b left=%0d want 101/1", occupied, spots_left); else chk_pass++;
    chk_total++; if (arrive_pulse !== 1'b1 || depart_pulse !== 1'b1)
      $display("FAIL mix_pulses: got arr=%b dep=%b want 1/1", arrive_pulse, depart_pulse); else chk_pass++;
    chk_total++; if (total_entries !== 8'd3) $display("FAIL mix_total: got %0d want 3", total_entries); else chk_pass++;
    chk_total++; if (full !== 1'b0 || empty !== 1'b0) $display("FAIL mix_flags: got full=%b empty=%b want 0/0", full, empty); else chk_pass++;
    tick(1);
    chk_total++; if (arrive_pulse !== 1'b0 || depart_pulse !== 1'b0)
      $display("FAIL mix_pulse_len: got arr=%b dep=%b want 0/0", arrive_pulse, depart_pulse); else chk_pass++;
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [5];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
    for (int k = 0; k < 5; k++) begin
      spot_sense2 = 3'b001;
      tick(6);
      chk_total++; if (total_entries2 !== exp_seq[k])
        $display("FAIL wrap_total[%0d]: got %0d want %0d", k, total_entries2, exp_seq[k]); else chk_pass++;
      spot_sense2 = 3'b000;
      tick(6);
    end
    spot_sense2 = 3'b001;
    tick(5);
    clear_stats2 = 1'b1;
    tick(1);
    clear_stats2 = 1'b0;
    chk_total++; if (total_entries2 !== 2'd0 || occupied2 !== 3'b001)
      $display("FAIL wrap_clear: got total=%0d occ=%b want 0/001", total_entries2, occupied2); else chk_pass++;
  endtask

  task automatic test_async_reset();
    int bad;
    spot_sense = 3'b111;
    tick(4);
    #3;
    reset = 1'b1;
    #1;
    chk_total++; if (occupied !== 3'b000 || spots_left !== 2'd3 || empty !== 1'b1 || full !== 1'b0)
      $display("FAIL arst_occ: got occ=%b left=%0d empty=%b full=%b want 000/3/1/0", occupied, spots_left, empty, full); else chk_pass++;
    chk_total++; if (total_entries !== 8'd0 || arrive_pulse !== 1'b0 || depart_pulse !== 1'b0)
      $display("FAIL arst_stats: got total=%0d arr=%b dep=%b want 0/0/0", total_entries, arrive_pulse, depart_pulse); else chk_pass++;
    #2;
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (occupied !== 3'b000 || arrive_pulse !== 1'b0 || depart_pulse !== 1'b0) bad++;
    end
    chk_total++; if (bad !== 0) $display("FAIL arst_spurious: got %0d bad cycles want 0", bad); else chk_pass++;
    tick(1);
    chk_total++; if (occupied !== 3'b111 || arrive_pulse !== 1'b1 || total_entries !== 8'd3)
      $display("FAIL arst_redeb: got occ=%b arr=%b total=%0d want 111/1/3", occupied, arrive_pulse, total_entries); else chk_pass++;
  endtask

  task automatic test_peak();
    logic [1:0] exp_full;
    logic [1:0] exp_one;
`ifdef PARKING_PEAK_TRACK_EN
    exp_full = 2'd3; exp_one = 2'd1;
`else
    exp_full = 2'd0; exp_one = 2'd0;
`endif
    spot_sense = 3'b000;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    spot_sense = 3'b111;
    tick(6);
    chk_total++; if (occupied !== 3'b111 || peak_occ !== 2'd0)
      $display("FAIL peak_lag: got occ=%b peak=%0d want 111/0", occupied, peak_occ); else chk_pass++;
    tick(1);
    chk_total++; if (peak_occ !== exp_full) $display("FAIL peak_fill: got %0d want %0d", peak_occ, exp_full); else chk_pass++;
    spot_sense = 3'b100;
    tick(8);
    chk_total++; if (occupied !== 3'b100 || spots_left !== 2'd2 || peak_occ !== exp_full)
      $display("FAIL peak_hold: got occ=%b left=%0d peak=%0d want 100/2/%0d", occupied, spots_left, peak_occ, exp_full); else chk_pass++;
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    chk_total++; if (peak_occ !== exp_one || total_entries !== 8'd0)
      $display("FAIL peak_clear: got peak=%0d total=%0d want %0d/0", peak_occ, total_entries, exp_one); else chk_pass++;
  endtask

  initial begin
    chk_total = 0;
    chk_pass  = 0;
    test_reset();
    test_glitch();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_peak();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
